// File: rtl/tl_source_tracker_if.sv
// TileLink A/D channel bundle snooped by tl_source_tracker.
// master drives the bus, slave only observes it.
interface tl_source_tracker_if #(
  parameter int SOURCE_W = 2
) ();
  logic                a_valid;
  logic                a_ready;
  logic [2:0]          a_opcode;
  logic [2:0]          a_size;
  logic [SOURCE_W-1:0] a_source;
  logic [31:0]         a_address;
  logic                d_valid;
  logic                d_ready;
  logic [2:0]          d_opcode;
  logic [2:0]          d_size;
  logic [SOURCE_W-1:0] d_source;

  modport master (
    output a_valid, a_ready, a_opcode, a_size, a_source, a_address,
    output d_valid, d_ready, d_opcode, d_size, d_source
  );

  modport slave (
    input a_valid, a_ready, a_opcode, a_size, a_source, a_address,
    input d_valid, d_ready, d_opcode, d_size, d_source
  );
endinterface

// File: rtl/tl_source_tracker.sv
// Passive TileLink-UL/UH tracker: per-source in-flight table, beat counting and
// A/D pairing checks with registered error pulses and an occupancy view.
module tl_source_tracker #(
  parameter int SOURCE_W = 2,
  parameter int BEAT_LG  = 2,
  parameter int TIMEOUT  = 1024
) (
  input  logic                     clock,
  input  logic                     reset,
  tl_source_tracker_if.slave       tl,
  output logic [2**SOURCE_W-1:0]   inflight,
  output logic [SOURCE_W:0]        outstanding,
  output logic                     err_valid,
  output logic [3:0]               err_code,
  output logic [SOURCE_W-1:0]      err_source,
  output logic                     err_sticky
);
  localparam int N    = 2**SOURCE_W;
  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, BURST} burst_e;

  burst_e              a_state, d_state;
  logic [7:0]          a_left, d_left;
  logic [2:0]          a_op_q, a_sz_q, d_op_q, d_sz_q;
  logic [SOURCE_W-1:0] a_src_q, d_src_q;
  logic [2:0]          exp_op [N];
  logic [2:0]          exp_sz [N];
  logic [WD_W-1:0]     wd;

  function automatic logic [7:0] beats_of(input logic [2:0] size);
    beats_of = 8'd1;
    if (int'(size) > BEAT_LG) beats_of = 8'(1 << (int'(size) - BEAT_LG));
  endfunction

  function automatic logic [2:0] exp_d_op(input logic [2:0] op);
    case (op)
      3'd0, 3'd1:       exp_d_op = 3'd0;
      3'd2, 3'd3, 3'd4: exp_d_op = 3'd1;
      default:          exp_d_op = 3'd2;
    endcase
  endfunction

  logic                a_fire, a_first, a_busy, a_alloc;
  logic [7:0]          a_beats;
  logic [31:0]         a_mask;
  logic                d_fire, d_first, d_last, d_free;
  logic [7:0]          d_beats;
  logic [SOURCE_W-1:0] d_src;
  logic                wd_hit;
  logic [8:0]          errs;
  logic [N-1:0]        inf_nx;
  logic [SOURCE_W:0]   out_nx;
  logic [SOURCE_W-1:0] low_src, src_nx;
  logic [3:0]          code_nx;
  logic                found, low_found;

  always_comb begin
    a_fire  = tl.a_valid & tl.a_ready;
    a_first = (a_state == IDLE);
    a_beats = (tl.a_opcode <= 3'd3) ? beats_of(tl.a_size) : 8'd1;
    a_mask  = (32'h1 << tl.a_size) - 32'h1;

    d_fire  = tl.d_valid & tl.d_ready;
    d_first = (d_state == IDLE);
    d_beats = (tl.d_opcode == 3'd1) ? beats_of(tl.d_size) : 8'd1;
    d_last  = d_first ? (d_beats == 8'd1) : (d_left == 8'd1);
    d_src   = d_first ? tl.d_source : d_src_q;
    d_free  = d_fire & d_last;

    // A same-cycle last D beat on this source frees the entry before A looks at it.
    a_busy  = inflight[tl.a_source] & ~(d_free & (d_src == tl.a_source));
    a_alloc = a_fire & a_first & (tl.a_opcode <= 3'd5) & ~a_busy;

    wd_hit  = ~d_fire & (outstanding != '0) & (wd == WD_W'(TIMEOUT - 1));

    errs    = '0;
    errs[0] = a_fire & a_first & (tl.a_opcode <= 3'd5) & a_busy;
    errs[1] = a_fire & ~a_first & ((tl.a_opcode != a_op_q) | (tl.a_size != a_sz_q) |
                                   (tl.a_source != a_src_q));
    errs[2] = a_fire & a_first & (tl.a_opcode >= 3'd6);
    errs[3] = a_fire & a_first & ((tl.a_address & a_mask) != 32'h0);
    errs[4] = d_fire & d_first & ~inflight[tl.d_source];
    errs[5] = d_fire & d_first & inflight[tl.d_source] &
              (tl.d_opcode != exp_op[tl.d_source]);
    errs[6] = d_fire & d_first & inflight[tl.d_source] &
              (tl.d_size != exp_sz[tl.d_source]);
    errs[7] = d_fire & ~d_first & ((tl.d_opcode != d_op_q) | (tl.d_size != d_sz_q) |
                                   (tl.d_source != d_src_q));
    errs[8] = wd_hit;

    inf_nx = inflight;
    if (d_free)  inf_nx[d_src] = 1'b0;
    if (a_alloc) inf_nx[tl.a_source] = 1'b1;

    out_nx = '0;
    for (int unsigned i = 0; i < N; i++) out_nx = out_nx + (SOURCE_W+1)'(inf_nx[i]);

    low_src   = '0;
    low_found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (inflight[i] && !low_found) begin
        low_found = 1'b1;
        low_src   = SOURCE_W'(i);
      end
    end

    code_nx = '0;
    src_nx  = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < 9; i++) begin
      if (errs[i] && !found) begin
        found   = 1'b1;
        code_nx = 4'(i + 1);
        if (i < 4)      src_nx = tl.a_source;
        else if (i < 8) src_nx = tl.d_source;
        else            src_nx = low_src;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      inflight    <= '0;
      outstanding <= '0;
      err_valid   <= 1'b0;
      err_code    <= '0;
      err_source  <= '0;
      err_sticky  <= 1'b0;
      a_state     <= IDLE;
      d_state     <= IDLE;
      a_left      <= '0;
      d_left      <= '0;
      a_op_q      <= '0;
      a_sz_q      <= '0;
      a_src_q     <= '0;
      d_op_q      <= '0;
      d_sz_q      <= '0;
      d_src_q     <= '0;
      wd          <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        exp_op[i] <= '0;
        exp_sz[i] <= '0;
      end
    end else begin
      inflight    <= inf_nx;
      outstanding <= out_nx;
      err_valid   <= |errs;
      err_code    <= code_nx;
      err_source  <= src_nx;
      err_sticky  <= err_sticky | (|errs);

      if (a_fire) begin
        if (a_first) begin
          a_op_q  <= tl.a_opcode;
          a_sz_q  <= tl.a_size;
          a_src_q <= tl.a_source;
          if (a_beats > 8'd1) begin
            a_state <= BURST;
            a_left  <= a_beats - 8'd1;
          end
        end else begin
          a_left <= a_left - 8'd1;
          if (a_left == 8'd1) a_state <= IDLE;
        end
      end

      if (d_fire) begin
        if (d_first) begin
          d_op_q  <= tl.d_opcode;
          d_sz_q  <= tl.d_size;
          d_src_q <= tl.d_source;
          if (d_beats > 8'd1) begin
            d_state <= BURST;
            d_left  <= d_beats - 8'd1;
          end
        end else begin
          d_left <= d_left - 8'd1;
          if (d_left == 8'd1) d_state <= IDLE;
        end
      end

      if (a_alloc) begin
        exp_op[tl.a_source] <= exp_d_op(tl.a_opcode);
        exp_sz[tl.a_source] <= tl.a_size;
      end

      if (d_fire || outstanding == '0 || wd_hit) wd <= '0;
      else                                       wd <= wd + 1'b1;
    end
  end
endmodule

// File: tb/tb_tl_source_tracker.sv
// Bench for tl_source_tracker: vector table through a scoreboard queue, plus
// hand-written watchdog and mid-burst reset sequences.
module tb_tl_source_tracker;
  localparam int SW = 2;
  localparam int TO = 1024;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  tl_source_tracker_if #(.SOURCE_W(SW)) bus ();

  logic [3:0] inflight;
  logic [2:0] outstanding;
  logic       err_valid;
  logic [3:0] err_code;
  logic [1:0] err_source;
  logic       err_sticky;

  tl_source_tracker #(.SOURCE_W(SW), .BEAT_LG(2), .TIMEOUT(TO)) dut (
    .clock       (clock),
    .reset       (reset),
    .tl          (bus),
    .inflight    (inflight),
    .outstanding (outstanding),
    .err_valid   (err_valid),
    .err_code    (err_code),
    .err_source  (err_source),
    .err_sticky  (err_sticky)
  );

  typedef struct packed {
    logic [3:0] inf;
    logic [2:0] outs;
    logic       ev;
    logic [3:0] ec;
    logic [1:0] es;
    logic       st;
  } obs_t;

  typedef struct packed {
    logic        av;
    logic        ar;
    logic [2:0]  aop;
    logic [2:0]  asz;
    logic [1:0]  asrc;
    logic [31:0] aaddr;
    logic        dv;
    logic [2:0]  dop;
    logic [2:0]  dsz;
    logic [1:0]  dsrc;
    obs_t        exp;
  } vec_t;

  int   checks = 0;
  int   passed = 0;
  obs_t sbq[$];
  vec_t tbl[32];

  function automatic vec_t v(input logic av, input logic ar, input logic [2:0] aop,
                             input logic [2:0] asz, input logic [1:0] asrc,
                             input logic [31:0] aaddr, input logic dv, input logic [2:0] dop,
                             input logic [2:0] dsz, input logic [1:0] dsrc,
                             input logic [3:0] inf, input logic [2:0] outs, input logic ev,
                             input logic [3:0] ec, input logic [1:0] es, input logic st);
    vec_t r;
    r.av = av; r.ar = ar; r.aop = aop; r.asz = asz; r.asrc = asrc; r.aaddr = aaddr;
    r.dv = dv; r.dop = dop; r.dsz = dsz; r.dsrc = dsrc;
    r.exp.inf = inf; r.exp.outs = outs; r.exp.ev = ev;
    r.exp.ec = ec; r.exp.es = es; r.exp.st = st;
    return r;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.inf = inflight; o.outs = outstanding; o.ev = err_valid;
    o.ec = err_code; o.es = err_source; o.st = err_sticky;
    return o;
  endfunction

  task automatic check_obs(input string name, input obs_t got, input obs_t exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got inf=%b out=%0d ev=%b code=%0d src=%0d sticky=%b, expected inf=%b out=%0d ev=%b code=%0d src=%0d sticky=%b",
                  name, got.inf, got.outs, got.ev, got.ec, got.es, got.st,
                  exp.inf, exp.outs, exp.ev, exp.ec, exp.es, exp.st);
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  task automatic drive(input vec_t t);
    bus.a_valid   = t.av;
    bus.a_ready   = t.ar;
    bus.a_opcode  = t.aop;
    bus.a_size    = t.asz;
    bus.a_source  = t.asrc;
    bus.a_address = t.aaddr;
    bus.d_valid   = t.dv;
    bus.d_ready   = 1'b1;
    bus.d_opcode  = t.dop;
    bus.d_size    = t.dsz;
    bus.d_source  = t.dsrc;
  endtask

  task automatic step(input vec_t t, input string name);
    obs_t e;
    drive(t);
    sbq.push_back(t.exp);
    @(posedge clock);
    #1;
    e = sbq.pop_front();
    check_obs(name, sample(), e);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vec_t idle;
    vec_t t;
    obs_t zero;
    int   n;
    int   hit;
    int   extra;

    zero = '0;
    idle = v(0,1,0,0,0,0, 0,0,0,0, 4'b0000,0,0,0,0,0);

    //            av ar op sz src addr        dv op sz src  inf   out ev ec es st
    tbl[0]  = v(1,1,4,2,1,32'h100, 0,0,0,0, 4'b0010,1,0,0,0,0);
    tbl[1]  = v(0,1,0,0,0,32'h0,   0,0,0,0, 4'b0010,1,0,0,0,0);
    tbl[2]  = v(0,1,0,0,0,32'h0,   1,1,2,1, 4'b0000,0,0,0,0,0);
    tbl[3]  = v(1,0,4,2,2,32'h0,   0,0,0,0, 4'b0000,0,0,0,0,0);
    tbl[4]  = v(1,1,0,4,0,32'h0,   0,0,0,0, 4'b0001,1,0,0,0,0);
    tbl[5]  = v(1,1,0,4,0,32'h0,   0,0,0,0, 4'b0001,1,0,0,0,0);
    tbl[6]  = v(1,1,0,4,0,32'h0,   0,0,0,0, 4'b0001,1,0,0,0,0);
    tbl[7]  = v(1,1,0,4,0,32'h0,   0,0,0,0, 4'b0001,1,0,0,0,0);
    tbl[8]  = v(0,1,0,0,0,32'h0,   1,0,4,0, 4'b0000,0,0,0,0,0);
    tbl[9]  = v(1,1,4,2,2,32'h0,   0,0,0,0, 4'b0100,1,0,0,0,0);
    tbl[10] = v(1,1,4,2,2,32'h0,   0,0,0,0, 4'b0100,1,1,1,2,1);
    tbl[11] = v(0,1,0,0,0,32'h0,   0,0,0,0, 4'b0100,1,0,0,0,1);
    tbl[12] = v(0,1,0,0,0,32'h0,   1,0,2,3, 4'b0100,1,1,5,3,1);
    tbl[13] = v(0,1,0,0,0,32'h0,   1,1,2,2, 4'b0000,0,0,0,0,1);
    tbl[14] = v(1,1,4,2,0,32'h0,   0,0,0,0, 4'b0001,1,0,0,0,1);
    tbl[15] = v(0,1,0,0,0,32'h0,   1,0,2,0, 4'b0000,0,1,6,0,1);
    tbl[16] = v(1,1,4,2,1,32'h0,   0,0,0,0, 4'b0010,1,0,0,0,1);
    tbl[17] = v(1,1,4,2,1,32'h0,   1,1,2,1, 4'b0010,1,0,0,0,1);
    tbl[18] = v(1,1,4,2,3,32'h102, 0,0,0,0, 4'b1010,2,1,4,3,1);
    tbl[19] = v(1,1,7,2,0,32'h0,   0,0,0,0, 4'b1010,2,1,3,0,1);
    tbl[20] = v(0,1,0,0,0,32'h0,   1,1,2,1, 4'b1000,1,0,0,0,1);
    tbl[21] = v(0,1,0,0,0,32'h0,   1,1,2,3, 4'b0000,0,0,0,0,1);
    tbl[22] = v(1,1,4,2,0,32'h0,   0,0,0,0, 4'b0001,1,0,0,0,1);
    tbl[23] = v(0,1,0,0,0,32'h0,   1,1,3,0, 4'b0001,1,1,7,0,1);
    tbl[24] = v(0,1,0,0,0,32'h0,   1,1,3,0, 4'b0000,0,0,0,0,1);
    tbl[25] = v(1,1,2,3,1,32'h0,   0,0,0,0, 4'b0010,1,0,0,0,1);
    tbl[26] = v(1,1,2,2,1,32'h0,   0,0,0,0, 4'b0010,1,1,2,1,1);
    tbl[27] = v(0,1,0,0,0,32'h0,   1,1,3,1, 4'b0010,1,0,0,0,1);
    tbl[28] = v(0,1,0,0,0,32'h0,   1,1,3,2, 4'b0000,0,1,8,2,1);
    tbl[29] = v(1,1,4,2,2,32'h0,   0,0,0,0, 4'b0100,1,0,0,0,1);
    tbl[30] = v(0,1,0,0,0,32'h0,   1,0,3,2, 4'b0000,0,1,6,2,1);
    tbl[31] = v(1,1,6,2,1,32'h0,   1,0,2,3, 4'b0000,0,1,3,1,1);

    drive(idle);
    repeat (2) @(posedge clock);
    #1;
    check_obs("reset_state", sample(), zero);
    reset = 1'b1;

    for (int i = 0; i < 32; i++) step(tbl[i], $sformatf("vec%0d", i));

    // Watchdog: one outstanding Get, then silence on D.
    step(v(1,1,4,2,0,32'h0, 0,0,0,0, 4'b0001,1,0,0,0,1), "wd_get");
    drive(idle);
    n = 0;
    hit = 0;
    while (n < 2 * TO && hit == 0) begin
      @(posedge clock);
      #1;
      n++;
      if (err_valid) hit = 1;
    end
    check_int("wd_fired", hit, 1);
    check_int("wd_latency", n, TO);
    check_int("wd_code", int'(err_code), 9);
    check_int("wd_source", int'(err_source), 0);
    extra = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clock);
      #1;
      if (err_valid) extra++;
    end
    check_int("wd_single_pulse", extra, 0);

    // Reset in the middle of a 4-beat PutFull, then a fresh Get to the same source.
    step(v(1,1,0,4,1,32'h0, 0,0,0,0, 4'b0011,2,0,0,0,1), "burst_beat1");
    drive(v(1,1,0,4,1,32'h0, 0,0,0,0, 4'b0000,0,0,0,0,0));
    reset = 1'b0;
    sbq.push_back(zero);
    @(posedge clock);
    #1;
    check_obs("mid_burst_reset", sample(), sbq.pop_front());
    reset = 1'b1;
    step(v(1,1,4,2,1,32'h0, 0,0,0,0, 4'b0010,1,0,0,0,0), "post_reset_get");
    step(v(0,1,0,0,0,32'h0, 1,1,2,1, 4'b0000,0,0,0,0,0), "post_reset_ack");
    step(idle, "final_idle");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
